// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide issue path: instruction fields,
// md_op encoding and controller state encoding.
package md_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  localparam logic [2:0] MD_OP_NONE  = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_MULTU = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_DIVU  = 3'd4;
  localparam logic [2:0] MD_OP_MTHI  = 3'd5;
  localparam logic [2:0] MD_OP_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_class_decode.sv
// Classifies one instruction word as a long, short or HI/LO read op and
// supplies the md_op code that would be issued for it.
module md_class_decode
  import md_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_long,
  output logic        is_short,
  output logic        is_read,
  output logic [2:0]  md_op
);

  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_long  = 1'b0;
    is_short = 1'b0;
    is_read  = 1'b0;
    md_op    = MD_OP_NONE;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FN_MULT:  begin is_long  = 1'b1; md_op = MD_OP_MULT;  end
        FN_MULTU: begin is_long  = 1'b1; md_op = MD_OP_MULTU; end
        FN_DIV:   begin is_long  = 1'b1; md_op = MD_OP_DIV;   end
        FN_DIVU:  begin is_long  = 1'b1; md_op = MD_OP_DIVU;  end
        FN_MTHI:  begin is_short = 1'b1; md_op = MD_OP_MTHI;  end
        FN_MTLO:  begin is_short = 1'b1; md_op = MD_OP_MTLO;  end
        FN_MFHI,
        FN_MFLO:  is_read = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: launches ops from E, tracks their latency,
// interlocks HI/LO-class instructions in D and cancels ops hit by a flush.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic        valid_e,
  input  logic        flush,
  output logic        start,
  output logic [2:0]  md_op,
  output logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        stall_d,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

  md_state_t     state;
  logic [CW-1:0] cnt;
  logic          first;

  logic       long_d, short_d, read_d;
  logic       long_e, short_e, read_e;
  logic [2:0] op_d, op_e;
  logic       running;
  logic       unused_dec;

  md_class_decode u_dec_d (
    .instr    (instr_d),
    .is_long  (long_d),
    .is_short (short_d),
    .is_read  (read_d),
    .md_op    (op_d)
  );

  md_class_decode u_dec_e (
    .instr    (instr_e),
    .is_long  (long_e),
    .is_short (short_e),
    .is_read  (read_e),
    .md_op    (op_e)
  );

  assign unused_dec = ^{op_d, read_e};

  assign running = (state == ST_RUN);
  assign start   = valid_e & (long_e | short_e) & ~running & ~flush;
  assign md_op   = start ? op_e : MD_OP_NONE;
  assign cancel  = running & first & flush;
  // A cancel in the last run cycle (MUL_CYCLES==1) wins over done.
  assign done    = running & (cnt == CW'(1)) & ~cancel;
  assign busy    = start | running;
  assign stall_d = busy & (long_d | short_d | read_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && long_e) begin
            state <= ST_RUN;
            cnt   <= (op_e == MD_OP_MULT || op_e == MD_OP_MULTU) ?
                     CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            first <= 1'b1;
          end
        end
        ST_RUN: begin
          first <= 1'b0;
          cnt   <= cnt - CW'(1);
          if (cancel || cnt == CW'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_d && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed scenarios plus random traffic for md_issue_ctrl, checked against a
// cycle-count reference model of the issue/interlock rules.
module tb_md_issue_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, instr_e;
  logic        valid_e, flush;
  logic        start, cancel, busy, done, stall_d;
  logic [2:0]  md_op;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: remaining run cycles, cycles since issue, stall count
  int          m_rem = 0;
  int          m_age = 0;
  logic [31:0] m_scnt = 0;

  md_issue_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
    .valid_e(valid_e), .flush(flush), .start(start), .md_op(md_op),
    .cancel(cancel), .busy(busy), .done(done), .stall_d(stall_d),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'b000000, mid, fn};
  endfunction

  // Reference meaning of an instruction: issued op code (0 if not issuable),
  // whether it is HI/LO-class, and its run length (0 for short ops).
  function automatic int ref_op(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 0;
    case (int'(ins[5:0]))
      24: return 1; 25: return 2; 26: return 3; 27: return 4;
      17: return 5; 19: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_hilo(input logic [31:0] ins);
    return ref_op(ins) != 0 || (ins[31:26] == 6'd0 && (ins[5:0] == 6'd16 || ins[5:0] == 6'd18));
  endfunction

  function automatic int ref_len(input int op);
    if (op == 1 || op == 2) return MUL_N;
    if (op == 3 || op == 4) return DIV_N;
    return 0;
  endfunction

  int last_done_age;
  bit saw_cancel;

  // Apply inputs just after a rising edge, check mid-cycle, advance model at the edge.
  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic v, input logic f);
    bit running, e_can, e_done, e_start, e_busy, e_stall;
    int op;
    instr_d = d; instr_e = e; valid_e = v; flush = f;
    #4;
    running = (m_rem > 0);
    op      = ref_op(e);
    e_can   = running && m_age == 1 && f;
    e_done  = running && m_rem == 1 && !e_can;
    e_start = !running && v && op != 0 && !f;
    e_busy  = e_start || running;
    e_stall = e_busy && ref_hilo(d);
    check("start",     {31'd0, start},   {31'd0, e_start});
    check("md_op",     {29'd0, md_op},   e_start ? 32'(op) : 32'd0);
    check("cancel",    {31'd0, cancel},  {31'd0, e_can});
    check("done",      {31'd0, done},    {31'd0, e_done});
    check("busy",      {31'd0, busy},    {31'd0, e_busy});
    check("stall_d",   {31'd0, stall_d}, {31'd0, e_stall});
    check("stall_cnt", stall_cnt,        m_scnt);
    if (e_done) last_done_age = m_age;
    if (e_can) saw_cancel = 1;
    @(posedge clk);
    if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (e_can) begin m_rem = 0; m_age = 0; end
    else if (running) begin m_rem--; m_age++; end
    else if (e_start && ref_len(op) > 0) begin m_rem = ref_len(op); m_age = 1; end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_cancel", {31'd0, cancel}, 32'd0);
    check("rst_scnt",   stall_cnt,       32'd0);
    m_rem = 0; m_age = 0; m_scnt = 0;
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [5:0] FUNCTS [10] = '{6'd16, 6'd17, 6'd18, 6'd19, 6'd24,
                                         6'd25, 6'd26, 6'd27, 6'd33, 6'd0};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = rtype(FUNCTS[$urandom_range(0, 9)]);
    if ($urandom_range(0, 7) == 0) w[31:26] = 6'($urandom_range(1, 63));
    return w;
  endfunction

  logic [31:0] nop, mflo, mfhi;

  initial begin
    reset = 1'b1; instr_d = '0; instr_e = '0; valid_e = 1'b0; flush = 1'b0;
    nop  = rtype(6'd33);
    mflo = rtype(6'd18);
    mfhi = rtype(6'd16);
    #2;
    do_reset();

    // MULT with MFLO waiting: stalls C0..C5, done at C5, MFLO enters E at C6
    last_done_age = -1;
    step(mflo, rtype(6'd24), 1, 0);
    for (int i = 1; i <= MUL_N; i++) step(mflo, nop, 0, 0);
    check("mult_done_c", 32'(last_done_age), 32'(MUL_N));
    check("mult_scnt",   stall_cnt,          32'd6);
    step(nop, mflo, 1, 0);

    // DIVU with ADDU in D: no stall, done at C10
    last_done_age = -1;
    step(nop, rtype(6'd27), 1, 0);
    for (int i = 1; i <= DIV_N; i++) step(nop, nop, 0, 0);
    check("divu_done_c", 32'(last_done_age), 32'(DIV_N));
    step(nop, nop, 0, 0);

    // DIV cancelled at C1
    saw_cancel = 0; last_done_age = -1;
    step(nop, rtype(6'd26), 1, 0);
    step(nop, nop, 0, 1);
    check("div_cancel", {31'd0, saw_cancel}, 32'd1);
    for (int i = 0; i < DIV_N; i++) step(nop, nop, 0, 0);
    check("div_no_done", 32'(last_done_age), 32'hFFFF_FFFF);

    // MULT with late flush at C3 completes normally
    saw_cancel = 0; last_done_age = -1;
    step(nop, rtype(6'd24), 1, 0);
    for (int i = 1; i <= MUL_N; i++) step(nop, nop, 0, (i == 3));
    check("late_flush_nocancel", {31'd0, saw_cancel}, 32'd0);
    check("late_flush_done",     32'(last_done_age),  32'(MUL_N));

    // MTHI with MFHI in D: one stall cycle, then MFHI proceeds
    step(mfhi, rtype(6'd17), 1, 0);
    step(nop, mfhi, 1, 0);

    // Reset mid-DIV, then a MULT issues normally
    step(nop, rtype(6'd26), 1, 0);
    step(nop, nop, 0, 0);
    step(nop, nop, 0, 0);
    do_reset();
    step(nop, rtype(6'd24), 1, 0);
    for (int i = 1; i <= MUL_N; i++) step(nop, nop, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(rand_instr(), rand_instr(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
